// File: rtl/sccomp_run_ctrl_pkg.sv
// Shared types and helpers for the sccomp run controller.
package sccomp_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RSN_NONE    = 2'b00,
        RSN_HALT    = 2'b01,
        RSN_TIMEOUT = 2'b10,
        RSN_FAULT   = 2'b11
    } reason_t;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int REC_W   = PC_W + INSTR_W;

    // Step counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // End-of-run classification for the step being retired; a misaligned PC
    // outranks reaching the halt address, which outranks the watchdog.
    function automatic reason_t end_reason(input logic [31:0] pc,
                                           input logic [31:0] cnt,
                                           input logic [31:0] halt_pc,
                                           input logic [32:0] max_steps);
        if (pc[1:0] != 2'b00)
            return RSN_FAULT;
        else if (pc == halt_pc)
            return RSN_HALT;
        else if (({1'b0, cnt} + 33'd1) == max_steps)
            return RSN_TIMEOUT;
        else
            return RSN_NONE;
    endfunction

endpackage

// File: rtl/sccomp_run_ctrl_sync_fifo.sv
// Small synchronous FIFO for trace records; head entry is visible on dout.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // Empty FIFO presents zeros so the sink never sees stale payload.
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset because occupancy guards reads.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sccomp_run_ctrl.sv
// Run controller for sccomp: CPU reset sequencing, step gating, end-of-run
// detection and a back-pressured trace stream of retired {pc,instr}.
module sccomp_run_ctrl
    import sccomp_run_ctrl_pkg::*;
#(
    parameter int          RST_CYCLES  = 5,
    parameter int          MAX_STEPS   = 10000,
    parameter logic [31:0] HALT_PC     = 32'hFFFF_FFFC,
    parameter int          TRACE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        cpu_rstn,
    output logic        cpu_step_en,
    input  logic [31:0] cpu_pc,
    input  logic [31:0] cpu_instr,
    output logic        trc_valid,
    input  logic        trc_ready,
    output logic [31:0] trc_pc,
    output logic [31:0] trc_instr,
    output logic        busy,
    output logic        done,
    output logic [1:0]  reason,
    output logic [31:0] step_cnt
);
    localparam int RCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RST_CYCLES - 1);

    state_t           state;
    reason_t          rsn;
    reason_t          end_rsn;
    logic [RCNT_W-1:0] rcnt;
    logic             start_ok;
    logic             step;
    logic             fifo_full;
    logic             fifo_empty;
    logic [REC_W-1:0] rec_head;

    // A run may only be (re)launched from IDLE or DONE; launching flushes the trace.
    assign start_ok    = start && ((state == ST_IDLE) || (state == ST_DONE));
    // rst gates the CPU controls combinationally so the CPU is held the same cycle.
    assign step        = !rst && (state == ST_RUN) && !fifo_full;
    assign cpu_step_en = step;
    assign cpu_rstn    = !rst && ((state == ST_RUN) || (state == ST_DONE));
    assign busy        = (state == ST_RESET) || (state == ST_RUN);
    assign done        = (state == ST_DONE);
    assign reason      = rsn;
    assign end_rsn     = end_reason(cpu_pc, step_cnt, HALT_PC, 33'(MAX_STEPS));

    assign trc_valid = !fifo_empty;
    assign trc_pc    = rec_head[REC_W-1:INSTR_W];
    assign trc_instr = rec_head[INSTR_W-1:0];

    sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (start_ok),
        .push  (step),
        .din   ({cpu_pc, cpu_instr}),
        .pop   (trc_valid && trc_ready),
        .dout  (rec_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Run FSM with reset-hold counter, retired-step counter and latched end reason.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rcnt     <= '0;
            step_cnt <= '0;
            rsn      <= RSN_NONE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state    <= ST_RESET;
                        rcnt     <= '0;
                        step_cnt <= '0;
                        rsn      <= RSN_NONE;
                    end
                end
                ST_RESET: begin
                    if (rcnt == RCNT_LAST)
                        state <= ST_RUN;
                    else
                        rcnt <= rcnt + 1'b1;
                end
                ST_RUN: begin
                    if (step) begin
                        step_cnt <= sat_inc32(step_cnt);
                        if (end_rsn != RSN_NONE) begin
                            rsn   <= end_rsn;
                            state <= ST_DONE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sccomp_run_ctrl.sv
// Scoreboard bench for sccomp_run_ctrl with a program-table CPU model.
module tb_sccomp_run_ctrl;
    localparam int          RST_CYCLES  = 5;
    localparam int          MAX_STEPS   = 8;
    localparam int          TRACE_DEPTH = 4;
    localparam logic [31:0] HALT_PC     = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst, start, trc_ready;
    logic        cpu_rstn, cpu_step_en, trc_valid, busy, done;
    logic [31:0] cpu_pc, cpu_instr, trc_pc, trc_instr, step_cnt;
    logic [1:0]  reason;

    logic [31:0] prog_pc [16];
    logic [31:0] prog_in [16];
    int          idx;
    logic [63:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    bit          rnd_rdy = 1'b0;

    always #5 clk = ~clk;

    // CPU model: one table entry retires per enabled cycle, restarts on reset.
    always @(posedge clk) begin
        if (!cpu_rstn) idx <= 0;
        else if (cpu_step_en && idx < 15) idx <= idx + 1;
    end
    assign cpu_pc    = prog_pc[idx[3:0]];
    assign cpu_instr = prog_in[idx[3:0]];

    sccomp_run_ctrl #(
        .RST_CYCLES  (RST_CYCLES),
        .MAX_STEPS   (MAX_STEPS),
        .HALT_PC     (HALT_PC),
        .TRACE_DEPTH (TRACE_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cpu_rstn(cpu_rstn),
        .cpu_step_en(cpu_step_en), .cpu_pc(cpu_pc), .cpu_instr(cpu_instr),
        .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_pc(trc_pc),
        .trc_instr(trc_instr), .busy(busy), .done(done), .reason(reason),
        .step_cnt(step_cnt)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (rnd_rdy) trc_ready = ($urandom_range(0, 1) == 1);
    endtask

    task automatic smp();
        cyc();
        @(negedge clk);
    endtask

    task automatic set_linear(input logic [31:0] base);
        for (int i = 0; i < 16; i++) begin
            prog_pc[i] = base + 32'(4 * i);
            prog_in[i] = $urandom();
        end
    endtask

    // Reference: records retire in table order until the first end condition.
    task automatic load_and_expect(output logic [1:0] er, output int ek);
        er = 2'b00;
        ek = 0;
        for (int i = 0; i < 16; i++) begin
            ek = i + 1;
            exp_q.push_back({prog_pc[i], prog_in[i]});
            if (prog_pc[i][1:0] != 2'b00) begin er = 2'b11; break; end
            if (prog_pc[i] == HALT_PC)    begin er = 2'b01; break; end
            if (ek == MAX_STEPS)          begin er = 2'b10; break; end
        end
    endtask

    task automatic monitor();
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (!rst && trc_valid && trc_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_record: got %0h required none", {trc_pc, trc_instr});
                end else begin
                    e = exp_q.pop_front();
                    chk("trace_record", {trc_pc, trc_instr}, e);
                end
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input logic [1:0] er, input int ek, input bit drain);
        int n = 0;
        while (!done && n < 400) begin smp(); n++; end
        chk({nm, "_done"}, 64'(done), 64'd1);
        chk({nm, "_reason"}, 64'(reason), 64'(er));
        chk({nm, "_step_cnt"}, 64'(step_cnt), 64'(ek));
        chk({nm, "_step_en_off"}, 64'(cpu_step_en), 64'd0);
        chk({nm, "_busy_off"}, 64'(busy), 64'd0);
        if (drain) begin
            rnd_rdy = 1'b0;
            cyc();
            trc_ready = 1'b1;
            n = 0;
            while (exp_q.size() != 0 && n < 100) begin smp(); n++; end
            chk({nm, "_drained"}, 64'(exp_q.size()), 64'd0);
            exp_q.delete();
            smp();
            chk({nm, "_valid_empty"}, 64'(trc_valid), 64'd0);
            chk({nm, "_reason_held"}, 64'(reason), 64'(er));
        end
    endtask

    task automatic run_prog(input string nm, input bit poke, input bit drain);
        logic [1:0] er;
        int ek, n, bad_busy;
        load_and_expect(er, ek);
        pulse_start();
        n = 0;
        bad_busy = 0;
        @(negedge clk);
        while (!cpu_rstn && n < 50) begin
            if (!busy) bad_busy++;
            n++;
            @(negedge clk);
        end
        chk({nm, "_rstn_low_cycles"}, 64'(n), 64'(RST_CYCLES));
        chk({nm, "_busy_in_reset"}, 64'(bad_busy), 64'd0);
        if (poke) begin
            cyc();
            pulse_start();
        end
        wait_done(nm, er, ek, drain);
    endtask

    initial begin
        logic [1:0]  er;
        int          ek, n;
        logic [31:0] hold_pc, hold_in;
        rst = 1'b1; start = 1'b0; trc_ready = 1'b0;
        set_linear(32'h0);
        fork monitor(); join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_rstn", 64'(cpu_rstn), 64'd0);
        chk("rst_step_en", 64'(cpu_step_en), 64'd0);
        chk("rst_trc", {31'd0, trc_valid, trc_pc}, 64'd0);
        chk("rst_trc_instr", 64'(trc_instr), 64'd0);
        chk("rst_status", {busy, done, reason}, 64'd0);
        chk("rst_step_cnt", 64'(step_cnt), 64'd0);
        cyc();
        rst = 1'b0;
        trc_ready = 1'b1;

        // Halt at the fourth step.
        prog_pc[0] = 32'h0; prog_pc[1] = 32'h4; prog_pc[2] = 32'h8; prog_pc[3] = HALT_PC;
        run_prog("halt4", 1'b0, 1'b1);

        // Watchdog, with an ignored start while running.
        set_linear(32'h100);
        run_prog("timeout", 1'b1, 1'b1);

        // Misaligned PC at the third step.
        set_linear(32'h0);
        prog_pc[2] = 32'h6;
        run_prog("fault3", 1'b0, 1'b1);

        // Fault on the watchdog step beats timeout.
        set_linear(32'h0);
        prog_pc[7] = 32'h21;
        run_prog("fault_vs_timeout", 1'b0, 1'b1);

        // Halt on the watchdog step beats timeout.
        set_linear(32'h0);
        prog_pc[7] = HALT_PC;
        run_prog("halt_vs_timeout", 1'b0, 1'b1);

        // Randomised programs under random back-pressure.
        for (int r = 0; r < 10; r++) begin
            set_linear($urandom() & 32'h0FFF_FF00);
            for (int i = 0; i < 16; i++) begin
                n = $urandom_range(0, 9);
                if (n == 0) prog_pc[i] = HALT_PC;
                else if (n == 1) prog_pc[i] = prog_pc[i] | 32'($urandom_range(1, 3));
            end
            rnd_rdy = 1'b1;
            run_prog("random", 1'b0, 1'b1);
        end

        // Full trace FIFO stalls the CPU with a stable head record.
        set_linear(32'h200);
        rnd_rdy = 1'b0;
        trc_ready = 1'b0;
        load_and_expect(er, ek);
        pulse_start();
        repeat (RST_CYCLES + 12) smp();
        chk("stall_step_cnt", 64'(step_cnt), 64'd4);
        chk("stall_step_en", 64'(cpu_step_en), 64'd0);
        chk("stall_valid", 64'(trc_valid), 64'd1);
        chk("stall_head", {trc_pc, trc_instr}, {prog_pc[0], prog_in[0]});
        hold_pc = trc_pc;
        hold_in = trc_instr;
        repeat (3) smp();
        chk("stall_stable", {trc_pc, trc_instr}, {hold_pc, hold_in});
        cyc();
        trc_ready = 1'b1;
        cyc();
        trc_ready = 1'b0;
        repeat (4) smp();
        chk("one_pop_one_step", 64'(step_cnt), 64'd5);
        chk("restall_step_en", 64'(cpu_step_en), 64'd0);
        cyc();
        trc_ready = 1'b1;
        wait_done("stall_run", er, ek, 1'b1);

        // Synchronous reset mid-run with two records queued.
        set_linear(32'h300);
        trc_ready = 1'b0;
        load_and_expect(er, ek);
        pulse_start();
        n = 0;
        @(negedge clk);
        while (step_cnt < 32'd2 && n < 50) begin @(negedge clk); n++; end
        chk("pre_rst_step_cnt", 64'(step_cnt), 64'd2);
        chk("pre_rst_valid", 64'(trc_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_rstn_immediate", 64'(cpu_rstn), 64'd0);
        @(posedge clk);
        #1;
        exp_q.delete();
        chk("midrst_valid", 64'(trc_valid), 64'd0);
        chk("midrst_rstn", 64'(cpu_rstn), 64'd0);
        chk("midrst_step_cnt", 64'(step_cnt), 64'd0);
        chk("midrst_status", {busy, done, reason}, 64'd0);
        rst = 1'b0;

        // Restart from DONE discards records the sink never took.
        set_linear(32'h400);
        prog_pc[1] = HALT_PC;
        load_and_expect(er, ek);
        pulse_start();
        wait_done("undrained", er, ek, 1'b0);
        chk("undrained_valid", 64'(trc_valid), 64'd1);
        exp_q.delete();
        cyc();
        set_linear(32'h500);
        prog_pc[2] = HALT_PC;
        rnd_rdy = 1'b1;
        run_prog("after_flush", 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

endmodule
